// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the IF/ID instruction queue: state encoding,
// default NOP word and the packed entry layout.
package if_id_queue_pkg;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

endpackage

// File: rtl/if_id_entry.sv
// Enabled data register holding one queued instruction word plus its address.
module if_id_entry #(
    parameter int W = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
        end else if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/if_id_queue.sv
// Two-entry in-order skid buffer between fetch and decode.
// Optional performance counters are built when IF_ID_QUEUE_PERF_EN is defined.
module if_id_queue
    import if_id_queue_pkg::*;
#(
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEFAULT,
    parameter logic [31:0] RESET_PC  = 32'h0000_3000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid_i,
    input  logic [31:0] if_instr_i,
    input  logic [31:0] if_pc_i,
    output logic        if_ready_o,
    output logic        id_valid_o,
    output logic [31:0] id_instr_o,
    output logic [31:0] id_pc_o,
    input  logic        id_ready_i,
    input  logic        flush_i
`ifdef IF_ID_QUEUE_PERF_EN
    ,
    output logic [31:0] stall_cnt_o,
    output logic [31:0] flush_cnt_o
`endif
);

    logic [1:0] state_q, state_d;
    logic       push, pop;

    // Entry 0 is the head, entry 1 the skid register.
    logic   [1:0]       ent_en;
    entry_t [1:0]       ent_d;
    logic   [1:0][63:0] ent_q;
    entry_t             head, skid, offered;

    assign offered = '{instr: if_instr_i, pc: if_pc_i};
    assign head    = entry_t'(ent_q[0]);
    assign skid    = entry_t'(ent_q[1]);

    assign if_ready_o = (state_q != ST_FULL);
    assign id_valid_o = (state_q != ST_EMPTY);
    assign push       = if_valid_i & if_ready_o;
    assign pop        = id_valid_o & id_ready_i;

    always_comb begin
        state_d  = state_q;
        ent_en   = 2'b00;
        ent_d[0] = offered;
        ent_d[1] = offered;
        if (flush_i) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (push) begin
                        state_d   = ST_ONE;
                        ent_en[0] = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (push && !pop) begin
                        state_d   = ST_FULL;
                        ent_en[1] = 1'b1;
                    end else if (pop && !push) begin
                        state_d = ST_EMPTY;
                    end else if (push && pop) begin
                        ent_en[0] = 1'b1;
                    end
                end
                ST_FULL: begin
                    if (pop) begin
                        state_d   = ST_ONE;
                        ent_en[0] = 1'b1;
                        ent_d[0]  = skid;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        if_id_entry #(.W(64)) u_entry (
            .clk   (clk),
            .rst_n (rst_n),
            .en_i  (ent_en[gi]),
            .d_i   (ent_d[gi]),
            .q_o   (ent_q[gi])
        );
    end

    assign id_instr_o = id_valid_o ? head.instr : NOP_INSTR;
    assign id_pc_o    = id_valid_o ? head.pc    : RESET_PC;

`ifdef IF_ID_QUEUE_PERF_EN
    logic [31:0] stall_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            if (if_valid_i && !if_ready_o) stall_cnt_q <= stall_cnt_q + 32'd1;
            if (flush_i)                   flush_cnt_q <= flush_cnt_q + 32'd1;
        end
    end

    assign stall_cnt_o = stall_cnt_q;
    assign flush_cnt_o = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_queue.sv
// Self-checking bench for if_id_queue: vector table, corner sequences and a
// randomized run against a queue-based reference model.
module tb_if_id_queue;

    localparam logic [31:0] NOP = 32'h0000_0000;
    localparam logic [31:0] RPC = 32'h0000_3000;

    logic        clk;
    logic        rst_n;
    logic        if_valid_i;
    logic [31:0] if_instr_i;
    logic [31:0] if_pc_i;
    logic        if_ready_o;
    logic        id_valid_o;
    logic [31:0] id_instr_o;
    logic [31:0] id_pc_o;
    logic        id_ready_i;
    logic        flush_i;
`ifdef IF_ID_QUEUE_PERF_EN
    logic [31:0] stall_cnt_o;
    logic [31:0] flush_cnt_o;
`endif

    int tests;
    int fails;

    if_id_queue dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .if_valid_i (if_valid_i),
        .if_instr_i (if_instr_i),
        .if_pc_i    (if_pc_i),
        .if_ready_o (if_ready_o),
        .id_valid_o (id_valid_o),
        .id_instr_o (id_instr_o),
        .id_pc_o    (id_pc_o),
        .id_ready_i (id_ready_i),
        .flush_i    (flush_i)
`ifdef IF_ID_QUEUE_PERF_EN
        ,
        .stall_cnt_o(stall_cnt_o),
        .flush_cnt_o(flush_cnt_o)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                         input logic rdy, input logic fl);
        if_valid_i = v;
        if_pc_i    = pc;
        if_instr_i = ins;
        id_ready_i = rdy;
        flush_i    = fl;
    endtask

    task automatic check_empty(input string tag);
        chk({tag, " id_valid"}, {31'd0, id_valid_o}, 32'd0);
        chk({tag, " if_ready"}, {31'd0, if_ready_o}, 32'd1);
        chk({tag, " id_instr"}, id_instr_o, NOP);
        chk({tag, " id_pc"}, id_pc_o, RPC);
    endtask

    // Leaves the bench 1 time unit after a rising edge with reset released.
    task automatic do_reset();
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_empty("reset");
`ifdef IF_ID_QUEUE_PERF_EN
        chk("reset stall_cnt", stall_cnt_o, 32'd0);
        chk("reset flush_cnt", flush_cnt_o, 32'd0);
`endif
        rst_n = 1'b1;
    endtask

    typedef struct packed {
        logic        v;
        logic [31:0] pc;
        logic [31:0] ins;
        logic        rdy;
        logic        fl;
        logic        e_valid;
        logic        e_ready;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
    } vec_t;

    vec_t tbl[12];

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq[$];
    logic [31:0] m_stall;
    logic [31:0] m_flush;

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 1'b0, 1'b0);

        //            v  pc        instr          rdy fl  valid ready pc        instr
        tbl[0]  = '{1'b1, 32'h3000, 32'h2408_0005, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3000, 32'h2408_0005};
        tbl[1]  = '{1'b1, 32'h3004, 32'hA000_3004, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h2408_0005};
        tbl[2]  = '{1'b1, 32'h3008, 32'hA000_3008, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h2408_0005};
        tbl[3]  = '{1'b1, 32'h3008, 32'hA000_3008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3004, 32'hA000_3004};
        tbl[4]  = '{1'b1, 32'h3008, 32'hA000_3008, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3008, 32'hA000_3008};
        tbl[5]  = '{1'b0, 32'h300C, 32'hA000_300C, 1'b1, 1'b0, 1'b0, 1'b1, RPC,      NOP};
        tbl[6]  = '{1'b0, 32'h300C, 32'hA000_300C, 1'b1, 1'b0, 1'b0, 1'b1, RPC,      NOP};
        tbl[7]  = '{1'b1, 32'h3010, 32'hA000_3010, 1'b1, 1'b0, 1'b1, 1'b1, 32'h3010, 32'hA000_3010};
        tbl[8]  = '{1'b1, 32'h3014, 32'hA000_3014, 1'b0, 1'b0, 1'b1, 1'b0, 32'h3010, 32'hA000_3010};
        tbl[9]  = '{1'b1, 32'h3018, 32'hA000_3018, 1'b1, 1'b1, 1'b0, 1'b1, RPC,      NOP};
        tbl[10] = '{1'b1, 32'h301C, 32'hA000_301C, 1'b0, 1'b1, 1'b0, 1'b1, RPC,      NOP};
        tbl[11] = '{1'b1, 32'h3020, 32'hA000_3020, 1'b0, 1'b0, 1'b1, 1'b1, 32'h3020, 32'hA000_3020};

        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(tbl[i].v, tbl[i].pc, tbl[i].ins, tbl[i].rdy, tbl[i].fl);
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d id_valid", i), {31'd0, id_valid_o}, {31'd0, tbl[i].e_valid});
            chk($sformatf("vec%0d if_ready", i), {31'd0, if_ready_o}, {31'd0, tbl[i].e_ready});
            chk($sformatf("vec%0d id_pc", i), id_pc_o, tbl[i].e_pc);
            chk($sformatf("vec%0d id_instr", i), id_instr_o, tbl[i].e_ins);
            $display("[TB] vec%0d pc=%h valid=%0b ready=%0b", i, id_pc_o, id_valid_o, if_ready_o);
        end
`ifdef IF_ID_QUEUE_PERF_EN
        chk("table stall_cnt", stall_cnt_o, 32'd3);
        chk("table flush_cnt", flush_cnt_o, 32'd2);
`endif

        // Streaming with decode always ready: one word per cycle.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, RPC + 32'(4 * i), 32'hB000_0000 + 32'(i), 1'b1, 1'b0);
            @(posedge clk);
            #1;
            chk($sformatf("stream%0d id_pc", i), id_pc_o, RPC + 32'(4 * i));
            chk($sformatf("stream%0d id_valid", i), {31'd0, id_valid_o}, 32'd1);
            $display("[TB] stream%0d pc=%h", i, id_pc_o);
        end
`ifdef IF_ID_QUEUE_PERF_EN
        chk("stream stall_cnt", stall_cnt_o, 32'd0);
`endif

        // Flush while full with a word offered.
        do_reset();
        drive(1'b1, 32'h3000, 32'hC000_0000, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h3004, 32'hC000_0004, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("full if_ready", {31'd0, if_ready_o}, 32'd0);
        drive(1'b1, 32'h3008, 32'hC000_0008, 1'b0, 1'b1);
        @(posedge clk); #1;
        check_empty("flush_full");
`ifdef IF_ID_QUEUE_PERF_EN
        chk("flush flush_cnt", flush_cnt_o, 32'd1);
`endif
        $display("[TB] flush_full valid=%0b pc=%h", id_valid_o, id_pc_o);

        // Asynchronous reset between edges while full.
        drive(1'b1, 32'h3010, 32'hD000_0010, 1'b0, 1'b0);
        @(posedge clk); #1;
        drive(1'b1, 32'h3014, 32'hD000_0014, 1'b0, 1'b0);
        @(posedge clk); #1;
        chk("prereset if_ready", {31'd0, if_ready_o}, 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        check_empty("async_reset");
        $display("[TB] async_reset valid=%0b ready=%0b", id_valid_o, if_ready_o);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Randomized run against the reference model.
        do_reset();
        mq.delete();
        m_stall = 32'd0;
        m_flush = 32'd0;
        for (int i = 0; i < 400; i++) begin
            logic        v, rdy, fl;
            logic [31:0] pc, ins;
            int          n;
            v   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            fl  = ($urandom_range(0, 19) == 0);
            pc  = $urandom;
            ins = $urandom;
            drive(v, pc, ins, rdy, fl);
            n = mq.size();
            chk("rnd id_valid", {31'd0, id_valid_o}, {31'd0, n != 0});
            chk("rnd if_ready", {31'd0, if_ready_o}, {31'd0, n < 2});
            chk("rnd id_instr", id_instr_o, (n != 0) ? mq[0].instr : NOP);
            chk("rnd id_pc", id_pc_o, (n != 0) ? mq[0].pc : RPC);
            @(posedge clk);
            if (v && n == 2) m_stall = m_stall + 32'd1;
            if (fl) begin
                m_flush = m_flush + 32'd1;
                mq.delete();
            end else begin
                if (rdy && n > 0) mq.delete(0);
                if (v && n < 2) mq.push_back('{instr: ins, pc: pc});
            end
            #1;
`ifdef IF_ID_QUEUE_PERF_EN
            chk("rnd stall_cnt", stall_cnt_o, m_stall);
            chk("rnd flush_cnt", flush_cnt_o, m_flush);
`endif
            $display("[TB] rnd%0d v=%0b rdy=%0b fl=%0b depth=%0d", i, v, rdy, fl, mq.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
